status_fsm: RTL and testbench

// Tamagotchi mood/state controller; closes the loop with the level-processing stage.

---
 rtl/tamagotchi_pkg.sv | 37 +++
 rtl/dwell_timer.sv | 29 ++
 rtl/status_fsm.sv | 162 ++++++++++++++++
 tb/tb_status_fsm.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/tamagotchi_pkg.sv
// Shared status codes, need encoding and level helpers for the Tamagotchi controller
// and the level-processing stage.
package tamagotchi_pkg;

    typedef enum logic [2:0] {
        ST_FELIZ      = 3'b000,
        ST_ABURRIDO   = 3'b001,
        ST_CANSADO    = 3'b010,
        ST_DESCANSO   = 3'b011,
        ST_HAMBRIENTO = 3'b100,
        ST_ENFERMO    = 3'b101,
        ST_MUERTO     = 3'b110
    } status_e;

    typedef enum logic [1:0] {
        NEED_NONE = 2'd0,
        NEED_HAM  = 2'd1,
        NEED_CAN  = 2'd2,
        NEED_ABU  = 2'd3
    } need_e;

    localparam logic [2:0] LVL_MAX = 3'd5;

    function automatic logic [2:0] lvl_sat(input logic [2:0] lvl);
        return (lvl > LVL_MAX) ? LVL_MAX : lvl;
    endfunction

    function automatic status_e need_to_status(input need_e need);
        case (need)
            NEED_HAM: return ST_HAMBRIENTO;
            NEED_CAN: return ST_CANSADO;
            NEED_ABU: return ST_ABURRIDO;
            default:  return ST_FELIZ;
        endcase
    endfunction

endpackage

// File: rtl/dwell_timer.sv
// Saturating tick counter with synchronous clear; clear wins over tick.
module dwell_timer #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         tick_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    // Count ticks, hold at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (tick_i && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + W'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/status_fsm.sv
// Tamagotchi mood controller: slow-tick level rules plus fast-clock user overrides,
// producing the registered status code that steers the level stage.
module status_fsm
    import tamagotchi_pkg::*;
#(
    parameter int unsigned LOW_LVL     = 1,
    parameter int unsigned NEED_LVL    = 2,
    parameter int unsigned OK_LVL      = 4,
    parameter int unsigned DWELL_TICKS = 3,
    parameter int unsigned SLEEP_TO    = 20,
    parameter int unsigned MIN_REST    = 8
) (
    input  logic       clk,
    input  logic       regrst,
    input  logic       sclk_en,
    input  logic [2:0] h,
    input  logic [2:0] d,
    input  logic [2:0] e,
    input  logic       enMue,
    input  logic       regcurar,
    input  logic       regtest,
    input  logic       dormir,
    input  logic       despertar,
    output logic [2:0] status,
    output logic       state_chg
);

    localparam int unsigned TMR_W = $clog2(((SLEEP_TO > MIN_REST) ? SLEEP_TO : MIN_REST) + 1);
    localparam int unsigned DW_W  = $clog2(DWELL_TICKS + 1);
    localparam logic [2:0]  LOW_L  = 3'(LOW_LVL);
    localparam logic [2:0]  NEED_L = 3'(NEED_LVL);
    localparam logic [2:0]  OK_L   = 3'(OK_LVL);

    status_e         status_q, status_d;
    need_e           need_q, need_d, winner_s;
    logic            state_chg_q, regtest_q;
    logic [2:0]      hs, ds, es;
    logic            lo_h, lo_d, lo_e, sick_s, same_s, dwell_go_s, test_edge_s, chg_s;
    logic            dwell_clr_s, dwell_tick_s, tmr_at_sleep_s, rest_ok_s;
    logic [31:0]     dwell_run_s;
    logic [TMR_W-1:0] tmr_cnt_s;
    logic [DW_W-1:0]  dwell_cnt_s;

    assign hs   = lvl_sat(h);
    assign ds   = lvl_sat(d);
    assign es   = lvl_sat(e);
    assign lo_h = (hs <= LOW_L);
    assign lo_d = (ds <= LOW_L);
    assign lo_e = (es <= LOW_L);
    assign sick_s = (lo_h & lo_d) | (lo_h & lo_e) | (lo_d & lo_e)
                  | (hs == 3'd0) | (ds == 3'd0) | (es == 3'd0);
    assign test_edge_s    = regtest & ~regtest_q;
    assign chg_s          = (status_d != status_q);
    assign tmr_at_sleep_s = (tmr_cnt_s == TMR_W'(SLEEP_TO - 1));
    assign rest_ok_s      = (tmr_cnt_s >= TMR_W'(MIN_REST));

    // Winning need and its dwell run length; a tick with a new winner starts a run of one.
    always_comb begin
        if (hs <= NEED_L) begin
            winner_s = NEED_HAM;
        end else if (es <= NEED_L) begin
            winner_s = NEED_CAN;
        end else if (ds <= NEED_L) begin
            winner_s = NEED_ABU;
        end else begin
            winner_s = NEED_NONE;
        end
        same_s       = (winner_s != NEED_NONE) && (winner_s == need_q);
        dwell_run_s  = same_s ? (32'(dwell_cnt_s) + 32'd2) : 32'd1;
        dwell_go_s   = (winner_s != NEED_NONE) && (dwell_run_s >= DWELL_TICKS);
        dwell_tick_s = sclk_en && same_s;
        dwell_clr_s  = chg_s || (status_q != ST_FELIZ) || (sclk_en && !same_s);
        if (chg_s) begin
            need_d = NEED_NONE;
        end else if (sclk_en && (status_q == ST_FELIZ)) begin
            need_d = winner_s;
        end else begin
            need_d = need_q;
        end
    end

    // Next status: overrides first, then per-state tick rules.
    always_comb begin
        status_d = status_q;
        if (test_edge_s) begin
            status_d = (status_q == ST_MUERTO) ? ST_FELIZ : status_e'(status_q + 3'd1);
        end else if (enMue) begin
            status_d = ST_MUERTO;
        end else if (regcurar && (status_q == ST_ENFERMO)) begin
            status_d = ST_FELIZ;
        end else begin
            case (status_q)
                ST_FELIZ: begin
                    if (sclk_en && sick_s)          status_d = ST_ENFERMO;
                    else if (sclk_en && dwell_go_s) status_d = need_to_status(winner_s);
                    else                            status_d = status_q;
                end
                ST_HAMBRIENTO: begin
                    if (sclk_en && sick_s)          status_d = ST_ENFERMO;
                    else if (sclk_en && hs >= OK_L) status_d = ST_FELIZ;
                    else                            status_d = status_q;
                end
                ST_ABURRIDO: begin
                    if (sclk_en && sick_s)            status_d = ST_ENFERMO;
                    else if (sclk_en && hs <= NEED_L) status_d = ST_HAMBRIENTO;
                    else if (sclk_en && ds >= OK_L)   status_d = ST_FELIZ;
                    else                              status_d = status_q;
                end
                ST_CANSADO: begin
                    if (sclk_en && sick_s)                         status_d = ST_ENFERMO;
                    else if (dormir || (sclk_en && tmr_at_sleep_s)) status_d = ST_DESCANSO;
                    else if (sclk_en && es >= OK_L)                status_d = ST_FELIZ;
                    else                                           status_d = status_q;
                end
                ST_DESCANSO: begin
                    if (sclk_en && es == LVL_MAX)    status_d = ST_FELIZ;
                    else if (despertar && rest_ok_s) status_d = ST_FELIZ;
                    else if (sclk_en && hs <= LOW_L) status_d = ST_HAMBRIENTO;
                    else                             status_d = status_q;
                end
                ST_ENFERMO: status_d = status_q;
                ST_MUERTO:  status_d = status_q;
                default:    status_d = ST_FELIZ;
            endcase
        end
    end

    // Registered status, change pulse, test-button history and dwell winner.
    always_ff @(posedge clk) begin
        if (regrst) begin
            status_q    <= ST_FELIZ;
            state_chg_q <= 1'b0;
            regtest_q   <= 1'b0;
            need_q      <= NEED_NONE;
        end else begin
            status_q    <= status_d;
            state_chg_q <= chg_s;
            regtest_q   <= regtest;
            need_q      <= need_d;
        end
    end

    dwell_timer #(.W(TMR_W)) u_state_tmr (
        .clk    (clk),
        .rst    (regrst),
        .clr_i  (chg_s),
        .tick_i (sclk_en),
        .cnt_o  (tmr_cnt_s)
    );

    dwell_timer #(.W(DW_W)) u_dwell_tmr (
        .clk    (clk),
        .rst    (regrst),
        .clr_i  (dwell_clr_s),
        .tick_i (dwell_tick_s),
        .cnt_o  (dwell_cnt_s)
    );

    assign status    = status_q;
    assign state_chg = state_chg_q;

endmodule

// File: tb/tb_status_fsm.sv
// Scoreboard bench for status_fsm: each driven cycle queues its expected status and
// change pulse; a monitor pops and compares after every rising edge.
module tb_status_fsm;

    localparam logic [2:0] F = 3'b000, ABU = 3'b001, CAN = 3'b010, DES = 3'b011;
    localparam logic [2:0] HAM = 3'b100, ENF = 3'b101, MUE = 3'b110;

    typedef struct {
        logic [2:0] st;
        logic       chg;
        string      tag;
    } exp_t;

    logic       clk = 1'b0;
    logic       regrst, sclk_en, enMue, regcurar, regtest, dormir, despertar;
    logic [2:0] h, d, e;
    logic [2:0] status;
    logic       state_chg;

    exp_t       sb_q[$];
    exp_t       mon_e;
    logic [2:0] m_st = 3'b000;
    string      phase = "init";
    int         n_vec = 0;
    int         n_err = 0;

    status_fsm dut (
        .clk       (clk),
        .regrst    (regrst),
        .sclk_en   (sclk_en),
        .h         (h),
        .d         (d),
        .e         (e),
        .enMue     (enMue),
        .regcurar  (regcurar),
        .regtest   (regtest),
        .dormir    (dormir),
        .despertar (despertar),
        .status    (status),
        .state_chg (state_chg)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // One clock with current inputs; the change pulse is expected whenever status moves, except on reset.
    task automatic step(input logic [2:0] exp_st);
        exp_t x;
        x.st  = exp_st;
        x.chg = !regrst && (exp_st != m_st);
        x.tag = phase;
        m_st  = exp_st;
        sb_q.push_back(x);
        @(posedge clk);
        #2;
    endtask

    task automatic tick(input logic [2:0] exp_st);
        sclk_en = 1'b1;
        step(exp_st);
        sclk_en = 1'b0;
        step(exp_st);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb_q.size() != 0) begin
            mon_e = sb_q.pop_front();
            chk_eq({mon_e.tag, ".status"}, {29'd0, status}, {29'd0, mon_e.st});
            chk_eq({mon_e.tag, ".chg"}, {31'd0, state_chg}, {31'd0, mon_e.chg});
        end
    end

    initial begin
        logic [2:0] nx;
        regrst = 1'b1; sclk_en = 1'b0; enMue = 1'b0; regcurar = 1'b0;
        regtest = 1'b0; dormir = 1'b0; despertar = 1'b0;
        h = 3'd0; d = 3'd0; e = 3'd0;
        #2;

        phase = "reset";
        step(F); step(F);
        regrst = 1'b0;
        phase = "sick0";
        step(F);
        tick(ENF);

        phase = "cure_vs_death";
        regcurar = 1'b1; enMue = 1'b1;
        step(MUE);
        regcurar = 1'b0; enMue = 1'b0;
        step(MUE);
        phase = "dead_hold";
        h = 3'd5; d = 3'd5; e = 3'd5;
        for (int i = 0; i < 3; i++) tick(MUE);
        phase = "rst_mid_tick";
        regrst = 1'b1; sclk_en = 1'b1;
        step(F);
        regrst = 1'b0; sclk_en = 1'b0;
        step(F);

        phase = "cure";
        h = 3'd0;
        tick(ENF);
        h = 3'd5; regcurar = 1'b1;
        step(F);
        regcurar = 1'b0;
        step(F);

        phase = "dwell_ham";
        h = 3'd2;
        tick(F); tick(F); tick(HAM);
        h = 3'd5;
        tick(F);
        phase = "dwell_break";
        h = 3'd2;
        tick(F); tick(F);
        h = 3'd5;
        tick(F);
        h = 3'd2;
        tick(F); tick(F);
        phase = "dwell_switch";
        h = 3'd5; e = 3'd2;
        tick(F); tick(F); tick(CAN);

        phase = "sleep_timeout";
        for (int i = 1; i <= 20; i++) tick((i == 20) ? DES : CAN);
        phase = "wake_early";
        for (int i = 0; i < 5; i++) tick(DES);
        despertar = 1'b1;
        step(DES);
        despertar = 1'b0;
        step(DES);
        phase = "wake_ok";
        for (int i = 0; i < 3; i++) tick(DES);
        despertar = 1'b1;
        step(F);
        despertar = 1'b0;
        step(F);

        phase = "dormir";
        tick(F); tick(F); tick(CAN);
        dormir = 1'b1;
        step(DES);
        dormir = 1'b0;
        step(DES);
        phase = "rest_sat";
        e = 3'd7;
        tick(F);

        phase = "bored";
        e = 3'd5; d = 3'd2;
        tick(F); tick(F); tick(ABU);
        h = 3'd2;
        tick(HAM);
        h = 3'd5;
        tick(F);
        phase = "two_low";
        h = 3'd1; d = 3'd1;
        tick(ENF);
        h = 3'd5; d = 3'd5; regcurar = 1'b1;
        step(F);
        regcurar = 1'b0;

        phase = "test_walk";
        nx = F;
        for (int i = 0; i < 7; i++) begin
            nx = (nx == MUE) ? F : nx + 3'd1;
            regtest = 1'b1;
            step(nx);
            regtest = 1'b0;
            step(nx);
        end
        phase = "test_hold";
        regtest = 1'b1;
        step(ABU);
        for (int i = 0; i < 9; i++) step(ABU);
        regtest = 1'b0;
        step(ABU);
        phase = "test_over_mue";
        regtest = 1'b1; enMue = 1'b1;
        step(CAN);
        regtest = 1'b0;
        step(MUE);
        enMue = 1'b0;
        step(MUE);
        phase = "test_wrap";
        regtest = 1'b1;
        step(F);
        regtest = 1'b0;
        step(F);

        @(posedge clk);
        #2;
        chk_eq("sb_drained", sb_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
